// File: rtl/alu_pkg.sv
// Shared opcode, select-code and FSM definitions for the ALU issue sequencer.
// Consumers: alu_op_decode, alu_op_sequencer.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_MOV = 4'd0,
    OP_CMP = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_MUL = 4'd4,
    OP_DIV = 4'd5,
    OP_XOR = 4'd6,
    OP_AND = 4'd7,
    OP_NOT = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10
  } opcode_e;

  localparam logic [3:0] SEL_SUB  = 4'd0;
  localparam logic [3:0] SEL_ADD  = 4'd1;
  localparam logic [3:0] SEL_MUL  = 4'd2;
  localparam logic [3:0] SEL_MOV  = 4'd3;
  localparam logic [3:0] SEL_CMP  = 4'd4;
  localparam logic [3:0] SEL_DIV  = 4'd5;
  localparam logic [3:0] SEL_XOR  = 4'd6;
  localparam logic [3:0] SEL_AND  = 4'd7;
  localparam logic [3:0] SEL_NOT  = 4'd8;
  localparam logic [3:0] SEL_SHL  = 4'd9;
  localparam logic [3:0] SEL_SHR  = 4'd10;
  localparam logic [3:0] SEL_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_MUL_LAT = 3;
  localparam int DEF_DIV_LAT = 4;

  // Wide enough to hold the longest latency itself, so the counter never wraps.
  function automatic int cnt_width(input int mul_lat, input int div_lat);
    int max_lat;
    max_lat = (mul_lat > div_lat) ? mul_lat : div_lat;
    return $clog2(max_lat) + 1;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: ISA opcode -> ALU select code, latency, illegal flag.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int LAT_W   = cnt_width(DEF_MUL_LAT, DEF_DIV_LAT)
) (
  input  logic [3:0]       op,
  output logic [3:0]       select,
  output logic [LAT_W-1:0] latency,
  output logic             illegal,
  output logic             is_div
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    select  = SEL_NONE;
    latency = LAT_W'(1);
    illegal = 1'b0;
    is_div  = 1'b0;
    case (op)
      OP_MOV: select = SEL_MOV;
      OP_CMP: select = SEL_CMP;
      OP_ADD: select = SEL_ADD;
      OP_SUB: select = SEL_SUB;
      OP_MUL: begin
        select  = SEL_MUL;
        latency = LAT_W'(MUL_LAT);
      end
      OP_DIV: begin
        select  = SEL_DIV;
        latency = LAT_W'(DIV_LAT);
        is_div  = 1'b1;
      end
      OP_XOR: select = SEL_XOR;
      OP_AND: select = SEL_AND;
      OP_NOT: select = SEL_NOT;
      OP_SHL: select = SEL_SHL;
      OP_SHR: select = SEL_SHR;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU issue sequencer: accepts one op, holds operands/select for its latency, returns the result.
// Optional macro ALU_SEQ_BACK_TO_BACK_EN lets a new command be accepted in the response-handshake cycle.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N       = 4,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_select,
  input  logic [N-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_zero,
  output logic         rsp_err
);

  localparam int CNT_W = cnt_width(MUL_LAT, DIV_LAT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             illegal_q;
  logic             div_zero_q;

  logic [3:0]       dec_select;
  logic [CNT_W-1:0] dec_latency;
  logic             dec_illegal;
  logic             dec_is_div;

  logic             accept;
  logic             capture;
  logic             retire;
  logic [N-1:0]     cap_data;

  alu_op_decode #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .LAT_W   (CNT_W)
  ) u_decode (
    .op      (cmd_op),
    .select  (dec_select),
    .latency (dec_latency),
    .illegal (dec_illegal),
    .is_div  (dec_is_div)
  );

  assign accept  = cmd_valid && cmd_ready;
  assign capture = (state_q == ST_EXEC) && (cnt_q == '0);
  assign retire  = (state_q == ST_DONE) && rsp_ready;

  // Divide by zero overrides whatever the ALU produces.
  assign cap_data = div_zero_q ? {N{1'b1}} : alu_result;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
`ifdef ALU_SEQ_BACK_TO_BACK_EN
        cmd_ready = rsp_ready;
        if (rsp_ready) state_d = cmd_valid ? ST_EXEC : ST_IDLE;
`else
        if (rsp_ready) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= SEL_NONE;
      cnt_q      <= '0;
      illegal_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      if (accept) begin
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_select <= dec_select;
        cnt_q      <= dec_latency - CNT_W'(1);
        illegal_q  <= dec_illegal;
        div_zero_q <= dec_is_div && (cmd_b == '0);
      end else if (retire) begin
        alu_select <= SEL_NONE;
      end
      if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= cap_data;
      rsp_zero  <= (cap_data == '0);
      rsp_err   <= illegal_q || div_zero_q;
    end else if (retire) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU stub on the select/operand outputs.
module tb_alu_op_sequencer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_select;
  logic [N-1:0] alu_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic         rsp_zero;
  logic         rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.N(N), .MUL_LAT(3), .DIV_LAT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  // ALU result-select stage stand-in; unknown selects return 0.
  always_comb begin
    alu_result = '0;
    case (alu_select)
      4'd0:  alu_result = alu_a - alu_b;
      4'd1:  alu_result = alu_a + alu_b;
      4'd2:  alu_result = alu_a * alu_b;
      4'd3:  alu_result = alu_a;
      4'd4:  alu_result = alu_a - alu_b;
      4'd5:  alu_result = (alu_b == '0) ? '0 : alu_a / alu_b;
      4'd6:  alu_result = alu_a ^ alu_b;
      4'd7:  alu_result = alu_a & alu_b;
      4'd8:  alu_result = ~alu_a;
      4'd9:  alu_result = alu_a << 1;
      4'd10: alu_result = alu_a >> 1;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic wait_rsp(input string tag, output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic retire_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_retired"}, 32'(rsp_valid), 32'd0);
    check({tag, "_sel_idle"}, 32'(alu_select), 32'hF);
  endtask

  // Full transaction: accept, latency and select hold, response fields, optional DONE stall, retire.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [3:0] e_sel, input int e_lat,
                        input logic [N-1:0] e_data, input logic e_zero, input logic e_err,
                        input int hold);
    int n = 0;
    logic held = 1'b1;
    logic stable = 1'b1;
    wait_ready(tag);
    issue(op, a, b);
    check({tag, "_sel"}, 32'(alu_select), 32'(e_sel));
    check({tag, "_alu_a"}, 32'(alu_a), 32'(a));
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (alu_select !== e_sel) held = 1'b0;
    end
    check({tag, "_latency"}, 32'(n), 32'(e_lat));
    check({tag, "_sel_held"}, 32'(held), 32'd1);
    check({tag, "_data"}, 32'(rsp_data), 32'(e_data));
    check({tag, "_zero"}, 32'(rsp_zero), 32'(e_zero));
    check({tag, "_err"}, 32'(rsp_err), 32'(e_err));
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        if (rsp_valid !== 1'b1 || rsp_data !== e_data || rsp_err !== e_err || cmd_ready !== 1'b0)
          stable = 1'b0;
      end
      check({tag, "_done_stall"}, 32'(stable), 32'd1);
    end
    retire_rsp(tag);
  endtask

  initial begin
    int n;
    logic quiet;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_sel", 32'(alu_select), 32'hF);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //      tag     op     a      b      sel    lat data   z     e     hold
    run_op("add",  4'd2,  4'd3,  4'd4,  4'd1,  1,  4'd7,  1'b0, 1'b0, 0);
    run_op("mul",  4'd4,  4'd3,  4'd5,  4'd2,  3,  4'hF,  1'b0, 1'b0, 0);
    run_op("div0", 4'd5,  4'd9,  4'd0,  4'd5,  4,  4'hF,  1'b0, 1'b1, 0);
    run_op("div",  4'd5,  4'd8,  4'd2,  4'd5,  4,  4'd4,  1'b0, 1'b0, 0);
    run_op("ill",  4'd12, 4'd6,  4'd1,  4'hF,  1,  4'd0,  1'b1, 1'b1, 0);
    run_op("cmp",  4'd1,  4'd5,  4'd5,  4'd4,  1,  4'd0,  1'b1, 1'b0, 0);
    run_op("sub",  4'd3,  4'd2,  4'd3,  4'd0,  1,  4'hF,  1'b0, 1'b0, 5);
    run_op("not",  4'd8,  4'd5,  4'd0,  4'd8,  1,  4'hA,  1'b0, 1'b0, 0);
    run_op("shr",  4'd10, 4'd9,  4'd0,  4'd10, 1,  4'd4,  1'b0, 1'b0, 0);
    run_op("mov",  4'd0,  4'd0,  4'd7,  4'd3,  1,  4'd0,  1'b1, 1'b0, 0);

    // Response handshake and next command presented in the same cycle.
    wait_ready("b2b");
    issue(4'd6, 4'hA, 4'h6);
    wait_rsp("b2b_xor", n);
    check("b2b_xor_data", 32'(rsp_data), 32'hC);
    cmd_op    = 4'd7;
    cmd_a     = 4'hC;
    cmd_b     = 4'hA;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
`ifdef ALU_SEQ_BACK_TO_BACK_EN
    check("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("b2b_no_bubble_sel", 32'(alu_select), 32'd7);
    check("b2b_old_retired", 32'(rsp_valid), 32'd0);
`else
    check("b2b_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("b2b_bubble_sel", 32'(alu_select), 32'hF);
    check("b2b_bubble_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("b2b_late_sel", 32'(alu_select), 32'd7);
`endif
    wait_rsp("b2b_and", n);
    check("b2b_and_latency", 32'(n), 32'd1);
    check("b2b_and_data", 32'(rsp_data), 32'd8);
    retire_rsp("b2b_and");

    // Reset in the middle of a DIV must abandon it without a response.
    wait_ready("rst_mid");
    issue(4'd5, 4'd8, 4'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_sel", 32'(alu_select), 32'hF);
    check("midrst_alu_a", 32'(alu_a), 32'd0);
    check("midrst_alu_b", 32'(alu_b), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    #3;
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) quiet = 1'b0;
    end
    check("midrst_no_rsp", 32'(quiet), 32'd1);
    run_op("post_rst_add", 4'd2, 4'd9, 4'd9, 4'd1, 1, 4'd2, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
